lcd_8080_write_ctrl: RTL and testbench
======================================

LCD_8080_WRITE_CTRL -- requirements
Module: lcd_8080_write_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, command FIFO depth (power of two, 4..64).
REQ-002 SHALL have parameter DATA_W, default 16, LCD data bus width.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have ports write_n and read_n, input, 1 each, active-low strobes.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, combinational read data, zero read latency.
REQ-010 SHALL have port lcd_cs_n, output, 1, panel chip select, active low.
REQ-011 SHALL have port lcd_rs, output, 1, register select: 0 = command, 1 = data.
REQ-012 SHALL have port lcd_wr_n, output, 1, write strobe, active low.
REQ-013 SHALL have port lcd_rd_n, output, 1, read strobe, held at constant 1.
REQ-014 SHALL have port lcd_data, output, DATA_W, panel data bus.

Function
REQ-015 Register map SHALL be:
- addr0 DATA: write pushes {rs=1, writedata[DATA_W-1:0]}
- addr1 CMD: write pushes {rs=0, writedata[DATA_W-1:0]}
- addr2 STATUS
- addr3 TIMING
REQ-016 STATUS read SHALL return:
- bit0 busy: FSM not IDLE, or FIFO non-empty
- bit1 full
- bit2 overflow: sticky
- bits[14:8] FIFO level
- all other bits 0
REQ-017 Writing STATUS with writedata[2]=1 SHALL clear overflow; all other STATUS write bits are ignored.
REQ-018 TIMING SHALL hold wr_lo[3:0] and wr_hi[7:4]; it reads back in bits[7:0], with zeros elsewhere.
REQ-019 Reads of addr0/addr1 SHALL return 0; readdata SHALL be 0 whenever chipselect=0.
REQ-020 A push SHALL be accepted when level<FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-021 A push SHALL otherwise be dropped and set overflow.
- If a clear and a new overflow occur in the same cycle, overflow SHALL end set.
REQ-022 FSM states SHALL be IDLE, SETUP, WR_LO, WR_HI.
REQ-023 IDLE: when the FIFO is non-empty, pop the head, register rs/data, and go to SETUP.
- lcd_cs_n=0 is registered in the same cycle.
REQ-024 SETUP: lasts 1 cycle with lcd_wr_n=1; the FSM samples TIMING here, then goes to WR_LO.
REQ-025 WR_LO: lcd_wr_n=0 for wr_lo+1 cycles, then go to WR_HI.
REQ-026 WR_HI: lcd_wr_n=1 for wr_hi+1 cycles.
- Exit to SETUP with the next popped entry if the FIFO is non-empty (lcd_cs_n stays 0).
- Otherwise exit to IDLE with lcd_cs_n=1.
REQ-027 lcd_data and lcd_rs SHALL be stable from SETUP through the end of WR_HI.
- In IDLE they SHALL hold their last value.
REQ-028 All lcd_* outputs SHALL be driven from flops (glitch-free).
REQ-029 A TIMING write during a transfer SHALL take effect at the next SETUP only.
REQ-030 Per-word period SHALL be 3 + wr_lo + wr_hi cycles (5 cycles at reset timing).
REQ-031 Latency: a write accepted at edge N SHALL set lcd_cs_n=0 after edge N+1 and lcd_wr_n=0 after edge N+2, with the FSM in IDLE.

Reset
REQ-032 On reset_n=0, asynchronously:
- lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_data=0
- FIFO emptied, overflow=0, FSM=IDLE
- wr_lo=1, wr_hi=1
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no further strobe.
- Queued entries SHALL be lost.

Structure
REQ-034 Shared package lcd_ctrl_pkg SHALL hold:
- FSM state enum
- register address constants
- STATUS bit positions
- TIMING reset values
REQ-035 Sub-module lcd_cmd_fifo SHALL be a synchronous show-ahead FIFO of width DATA_W+1, with level output.

Verification
REQ-036 Reset with timing defaults: write DATA 0x1234.
- lcd_wr_n low exactly 2 cycles, with lcd_rs=1 and lcd_data=0x1234.
- lcd_cs_n returns to 1 after WR_HI.
REQ-037 Write CMD 0x002C then 3 DATA back-to-back.
- 4 strobes, 5 cycles apart; lcd_cs_n continuously 0.
- First strobe rs=0; remaining strobes rs=1.
REQ-038 Stall the panel and write 17 entries (FIFO_DEPTH=16) while the FSM is busy.
- Overflow=1; the 17th entry is never strobed.
- STATUS write 0x4 clears overflow.
REQ-039 TIMING=0x30 written mid-transfer.
- The current word keeps old timing.
- The next word shows wr_lo=1 cycle and wr_hi=4 cycles.
REQ-040 Assert reset_n during WR_LO of the 2nd of 3 queued words.
- lcd_wr_n and lcd_cs_n go to 1 immediately; STATUS reads 0 afterwards.
REQ-041 Push when full in the same cycle as a pop: the push is accepted, level unchanged, overflow stays 0.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the 8080-style LCD write controller.
// Holds the transfer FSM state encoding, the Avalon-MM register map,
// the STATUS bit layout and the reset values of the strobe timing.
package lcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WR_LO = 2'd2,
    ST_WR_HI = 2'd3
  } lcd_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_OVF       = 2;
  localparam int STATUS_LEVEL_LSB = 8;
  localparam int STATUS_LEVEL_W   = 7;

  localparam logic [3:0] WR_LO_RST = 4'd1;
  localparam logic [3:0] WR_HI_RST = 4'd1;

  // TIMING register image as seen on readdata.
  function automatic logic [31:0] timing_word(input logic [3:0] lo, input logic [3:0] hi);
    return {24'd0, hi, lo};
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued LCD words ({rs, data}).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset (empties FIFO)
//   push, push_data     write request and word; ignored when full unless
//                       a pop happens in the same cycle
//   pop                 consume the head word; ignored when empty
//   head_data           current head word (valid while !empty)
//   empty, full, level  occupancy flags and count (0..DEPTH)
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty     = (level == '0);
  assign full      = (level == LEVEL_FULL);
  assign rd_en     = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign wr_en     = push & (~full | rd_en);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: a word is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_8080_write_ctrl.sv
// Avalon-MM slave that queues command/data words and plays them out on an
// 8080-style parallel LCD write interface with programmable strobe timing.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   address, chipselect      Avalon-MM word address / select
//   write_n, read_n          active-low strobes
//   writedata, readdata      32-bit data; readdata is combinational
//   lcd_cs_n, lcd_rs         panel select (active low), 0=command 1=data
//   lcd_wr_n, lcd_rd_n       write strobe (active low), read strobe (always 1)
//   lcd_data                 panel data bus
// Register map: 0 DATA (push rs=1), 1 CMD (push rs=0), 2 STATUS, 3 TIMING.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | panel deselected; pops the FIFO head when one is queued
// ST_SETUP | word on bus, cs low, wr high for 1 cycle; samples TIMING
// ST_WR_LO | wr low for wr_lo+1 cycles
// ST_WR_HI | wr high for wr_hi+1 cycles, then next word or back to idle
module lcd_8080_write_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [DATA_W-1:0] lcd_data
);

  import lcd_ctrl_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              wr_access;
  logic              push;
  logic [DATA_W:0]   push_word;
  logic              pop;
  logic [DATA_W:0]   head_word;
  logic              fifo_empty;
  logic              fifo_full;
  logic [LW-1:0]     fifo_level;
  logic              ovf_set;
  logic              ovf_clr;
  logic              overflow;
  logic [3:0]        wr_lo;
  logic [3:0]        wr_hi;
  lcd_state_t        state;
  logic [3:0]        cnt;
  logic [3:0]        hi_len;
  logic [31:0]       rdata;
  logic              unused_inputs;

  assign unused_inputs = ^{read_n, writedata};

  assign wr_access = chipselect & ~write_n;
  assign push      = wr_access & ((address == ADDR_DATA) | (address == ADDR_CMD));
  assign push_word = {address == ADDR_DATA, writedata[DATA_W-1:0]};

  // Pop whenever the FSM is ready to present a new word.
  assign pop = ~fifo_empty &
               ((state == ST_IDLE) | ((state == ST_WR_HI) & (cnt == 4'd0)));

  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = wr_access & (address == ADDR_STATUS) & writedata[STATUS_OVF];

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_lo    <= WR_LO_RST;
      wr_hi    <= WR_HI_RST;
      overflow <= 1'b0;
    end else begin
      if (wr_access && (address == ADDR_TIMING)) begin
        wr_lo <= writedata[3:0];
        wr_hi <= writedata[7:4];
      end
      // A new drop in the clearing cycle wins over the clear.
      overflow <= (overflow & ~ovf_clr) | ovf_set;
    end
  end

  // Phase lengths run on a down-counter; the phase ends when it reads zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      hi_len   <= WR_HI_RST;
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_rd_n <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      lcd_rd_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            lcd_rs   <= head_word[DATA_W];
            lcd_data <= head_word[DATA_W-1:0];
            lcd_cs_n <= 1'b0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // TIMING is captured here so mid-word writes only affect later words.
          cnt      <= wr_lo;
          hi_len   <= wr_hi;
          lcd_wr_n <= 1'b0;
          state    <= ST_WR_LO;
        end
        ST_WR_LO: begin
          if (cnt == 4'd0) begin
            cnt      <= hi_len;
            lcd_wr_n <= 1'b1;
            state    <= ST_WR_HI;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR_HI: begin
          if (cnt == 4'd0) begin
            if (!fifo_empty) begin
              lcd_rs   <= head_word[DATA_W];
              lcd_data <= head_word[DATA_W-1:0];
              state    <= ST_SETUP;
            end else begin
              lcd_cs_n <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          lcd_cs_n <= 1'b1;
          lcd_wr_n <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_STATUS: begin
          rdata[STATUS_BUSY] = (state != ST_IDLE) | ~fifo_empty;
          rdata[STATUS_FULL] = fifo_full;
          rdata[STATUS_OVF]  = overflow;
          rdata[STATUS_LEVEL_LSB +: LW] = fifo_level;
        end
        ADDR_TIMING: rdata = timing_word(wr_lo, wr_hi);
        default:     rdata = '0;
      endcase
    end
  end

  assign readdata = rdata;

endmodule

// File: tb/tb_lcd_8080_write_ctrl.sv
module tb_lcd_8080_write_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;

  always #5 clk = ~clk;

  lcd_8080_write_ctrl #(.FIFO_DEPTH(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
    .lcd_data(lcd_data)
  );

  typedef struct {
    logic        rs;
    logic [15:0] data;
    int          lo_len;
    int          start;
    bit          stable;
  } strobe_t;

  strobe_t     obs[$];
  logic [16:0] exp_q[$];
  int          cyc = 0;
  int          cs_rise = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Strobe capture: one entry per completed low pulse of lcd_wr_n.
  initial begin : monitor
    strobe_t cur;
    bit      in_lo;
    logic    prev_cs;
    in_lo = 0;
    prev_cs = 1'b1;
    cur = '{rs: 1'b0, data: 16'h0, lo_len: 0, start: 0, stable: 1'b1};
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        in_lo = 0;
      end else if (lcd_wr_n === 1'b0) begin
        if (!in_lo) begin
          in_lo = 1;
          cur.rs = lcd_rs; cur.data = lcd_data; cur.start = cyc;
          cur.lo_len = 0; cur.stable = 1'b1;
        end
        cur.lo_len++;
        if (lcd_rs !== cur.rs || lcd_data !== cur.data || lcd_cs_n !== 1'b0) cur.stable = 1'b0;
      end else if (in_lo) begin
        in_lo = 0;
        if (lcd_rs !== cur.rs || lcd_data !== cur.data || lcd_cs_n !== 1'b0) cur.stable = 1'b0;
        obs.push_back(cur);
      end
      if (prev_cs === 1'b0 && lcd_cs_n === 1'b1) cs_rise++;
      prev_cs = lcd_cs_n;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic push_word(input logic rs, input logic [15:0] d, input bit accepted);
    if (accepted) exp_q.push_back({rs, d});
    bus_write(rs ? 2'd0 : 2'd1, {16'h0, d});
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1 d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs} !== 4'b1110) begin
      n_err++; $display("FAIL reset_pins: got cs/wr/rd/rs=%b want 1110", {lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs}); end
    n_vec++; if (lcd_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", lcd_data); end
    reset_n = 1'b1;
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", rd); end
    bus_read(2'd3, rd);
    n_vec++; if (rd !== 32'h11) begin n_err++; $display("FAIL reset_timing: got %h want 11", rd); end
    bus_read(2'd0, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL read_data_addr: got %h want 0", rd); end
    bus_read(2'd1, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL read_cmd_addr: got %h want 0", rd); end
    @(negedge clk);
    address = 2'd3; chipselect = 1'b0; read_n = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL cs_low_read: got %h want 0", readdata); end
    read_n = 1'b1;
  endtask

  task automatic test_single;
    strobe_t s; logic [16:0] e; bit ok; int r0; logic [31:0] rd;
    r0 = cs_rise;
    push_word(1'b1, 16'h1234, 1);
    @(negedge clk);
    n_vec++; if (lcd_cs_n !== 1'b1) begin n_err++; $display("FAIL lat_cs_n0: got %b want 1", lcd_cs_n); end
    @(negedge clk);
    n_vec++; if ({lcd_cs_n, lcd_wr_n} !== 2'b01) begin n_err++; $display("FAIL lat_setup: got cs/wr=%b want 01", {lcd_cs_n, lcd_wr_n}); end
    @(negedge clk);
    n_vec++; if (lcd_wr_n !== 1'b0) begin n_err++; $display("FAIL lat_wr_n2: got %b want 0", lcd_wr_n); end
    wait_strobes(1, 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout: got %0d strobes want 1", obs.size()); end
    if (ok) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e) begin n_err++; $display("FAIL single_word: got %h want %h", {s.rs, s.data}, e); end
      n_vec++; if (s.lo_len !== 2) begin n_err++; $display("FAIL single_lo_len: got %0d want 2", s.lo_len); end
      n_vec++; if (!s.stable) begin n_err++; $display("FAIL single_stable: got unstable want stable"); end
    end
    repeat (6) @(negedge clk);
    n_vec++; if (cs_rise - r0 !== 1 || lcd_cs_n !== 1'b1) begin
      n_err++; $display("FAIL single_cs_release: got rises=%0d cs_n=%b want 1/1", cs_rise - r0, lcd_cs_n); end
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL single_idle_status: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back;
    strobe_t s; logic [16:0] e; bit ok; int r0; int prev;
    r0 = cs_rise; prev = 0;
    push_word(1'b0, 16'h002C, 1);
    push_word(1'b1, 16'hA001, 1);
    push_word(1'b1, 16'hA002, 1);
    push_word(1'b1, 16'hA003, 1);
    wait_strobes(4, 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d strobes want 4", obs.size()); end
    for (int i = 0; i < 4 && obs.size() > 0; i++) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e || !s.stable) begin
        n_err++; $display("FAIL b2b_word%0d: got %h stable=%0b want %h", i, {s.rs, s.data}, s.stable, e); end
      n_vec++; if (s.lo_len !== 2) begin n_err++; $display("FAIL b2b_lo_len%0d: got %0d want 2", i, s.lo_len); end
      if (i > 0) begin
        n_vec++; if (s.start - prev !== 5) begin n_err++; $display("FAIL b2b_period%0d: got %0d want 5", i, s.start - prev); end
      end
      prev = s.start;
    end
    exp_q.delete();
    repeat (8) @(negedge clk);
    n_vec++; if (cs_rise - r0 !== 1) begin n_err++; $display("FAIL b2b_cs_continuous: got %0d rises want 1", cs_rise - r0); end
  endtask

  task automatic test_timing_change;
    strobe_t s; logic [16:0] e; bit ok; int prev;
    int exp_lo[3]; int exp_per[3];
    exp_lo = '{2, 1, 1}; exp_per = '{0, 5, 6};
    prev = 0;
    bus_write(2'd3, 32'h11);
    push_word(1'b1, 16'hC001, 1);
    push_word(1'b1, 16'hC002, 1);
    push_word(1'b1, 16'hC003, 1);
    bus_write(2'd3, 32'h30);
    wait_strobes(3, 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL tim_timeout: got %0d strobes want 3", obs.size()); end
    for (int i = 0; i < 3 && obs.size() > 0; i++) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e) begin n_err++; $display("FAIL tim_word%0d: got %h want %h", i, {s.rs, s.data}, e); end
      n_vec++; if (s.lo_len !== exp_lo[i]) begin n_err++; $display("FAIL tim_lo_len%0d: got %0d want %0d", i, s.lo_len, exp_lo[i]); end
      if (i > 0) begin
        n_vec++; if (s.start - prev !== exp_per[i]) begin
          n_err++; $display("FAIL tim_period%0d: got %0d want %0d", i, s.start - prev, exp_per[i]); end
      end
      prev = s.start;
    end
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overflow;
    strobe_t s; logic [16:0] e; bit ok; logic [31:0] rd; int bad;
    bus_write(2'd3, 32'hFF);
    push_word(1'b1, 16'h5000, 1);
    for (int i = 1; i <= 17; i++) push_word(1'b1, 16'h5000 + 16'(i), i < 17);
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0000_1007) begin n_err++; $display("FAIL ovf_status: got %h want 00001007", rd); end
    @(negedge clk);
    address = 2'd2; chipselect = 1'b0; read_n = 1'b0;
    #1;
    n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL ovf_cs_low_read: got %h want 0", readdata); end
    read_n = 1'b1;
    bus_write(2'd2, 32'hFFFF_FFFB);
    bus_read(2'd2, rd);
    n_vec++; if (rd[2] !== 1'b1) begin n_err++; $display("FAIL ovf_other_bits: got ovf=%b want 1", rd[2]); end
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0000_1003) begin n_err++; $display("FAIL ovf_clear: got %h want 00001003", rd); end
    wait_strobes(17, 700, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: got %0d strobes want 17", obs.size()); end
    bad = 0;
    for (int i = 0; i < 17 && obs.size() > 0; i++) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e || s.lo_len !== 16) begin
        n_err++; $display("FAIL ovf_word%0d: got %h lo=%0d want %h lo=16", i, {s.rs, s.data}, s.lo_len, e); end
    end
    repeat (40) @(negedge clk);
    n_vec++; if (obs.size() !== 0 || exp_q.size() !== 0) begin
      n_err++; $display("FAIL ovf_dropped_word: got extra=%0d missing=%0d want 0/0", obs.size(), exp_q.size()); end
    obs.delete(); exp_q.delete();
  endtask

  task automatic test_full_pop;
    strobe_t s; logic [16:0] e; bit ok; bit was_low; bit hit; logic [31:0] rd;
    bus_write(2'd3, 32'h1F);
    push_word(1'b1, 16'h7000, 1);
    for (int i = 1; i <= 16; i++) push_word(1'b0, 16'h7000 + 16'(i), 1);
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0000_1003) begin n_err++; $display("FAIL fp_full: got %h want 00001003", rd); end
    was_low = 0; hit = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lcd_wr_n === 1'b1 && was_low) begin hit = 1; break; end
      was_low = (lcd_wr_n === 1'b0);
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL fp_lead_timeout: got no strobe end want one"); end
    push_word(1'b1, 16'hBEEF, 1);
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0000_1003) begin n_err++; $display("FAIL fp_push_pop: got %h want 00001003", rd); end
    wait_strobes(18, 420, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fp_timeout: got %0d strobes want 18", obs.size()); end
    for (int i = 0; i < 18 && obs.size() > 0; i++) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e) begin n_err++; $display("FAIL fp_word%0d: got %h want %h", i, {s.rs, s.data}, e); end
    end
    obs.delete(); exp_q.delete();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    strobe_t s; logic [16:0] e; logic [31:0] rd; logic prev_wr; int falls;
    bus_write(2'd3, 32'h12);
    push_word(1'b1, 16'h9001, 1);
    push_word(1'b1, 16'h9002, 1);
    push_word(1'b1, 16'h9003, 1);
    prev_wr = 1'b1; falls = 0;
    for (int i = 0; i < 60 && falls < 2; i++) begin
      @(negedge clk);
      if (lcd_wr_n === 1'b0 && prev_wr === 1'b1) falls++;
      prev_wr = lcd_wr_n;
    end
    n_vec++; if (falls !== 2) begin n_err++; $display("FAIL rm_second_strobe: got %0d falls want 2", falls); end
    reset_n = 1'b0;
    #1;
    n_vec++; if ({lcd_wr_n, lcd_cs_n} !== 2'b11) begin
      n_err++; $display("FAIL rm_async_abort: got wr/cs=%b want 11", {lcd_wr_n, lcd_cs_n}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, rd);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rm_status: got %h want 0", rd); end
    bus_read(2'd3, rd);
    n_vec++; if (rd !== 32'h11) begin n_err++; $display("FAIL rm_timing: got %h want 11", rd); end
    repeat (20) @(negedge clk);
    n_vec++; if (obs.size() !== 1) begin n_err++; $display("FAIL rm_strobe_count: got %0d want 1", obs.size()); end
    if (obs.size() > 0) begin
      s = obs.pop_front(); e = exp_q.pop_front();
      n_vec++; if ({s.rs, s.data} !== e) begin n_err++; $display("FAIL rm_first_word: got %h want %h", {s.rs, s.data}, e); end
    end
    exp_q.delete();
    n_vec++; if (lcd_cs_n !== 1'b1) begin n_err++; $display("FAIL rm_cs_idle: got %b want 1", lcd_cs_n); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_timing_change;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
